// File: rtl/boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : boot_sequencer
// Description : Power-on / boot reset controller. Waits for PLL lock, pulses
//               reset to the loaders, waits for every loader to report ready,
//               holds the CPU in reset for a minimum time, then runs.
//               Debounces the reset button, retries loaders on timeout and
//               drives the boot-status LED.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_sequencer #(
    parameter int NUM_READY           = 1,
    parameter int SYNC_STAGES         = 2,
    parameter int DEBOUNCE_CYCLES     = 65536,
    parameter int LOADER_RESET_CYCLES = 4,
    parameter int HOLD_CYCLES         = 16,
    parameter int LOAD_TIMEOUT        = 0,
    parameter int RELOAD_ON_BTN       = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pll_locked,
    input  logic                 btn_n,
    input  logic [NUM_READY-1:0] ready,
    output logic                 loader_reset,
    output logic                 cpu_reset,
    output logic                 boot_done,
    output logic                 led_n,
    output logic                 timeout_err,
    output logic [7:0]           retry_count
);

    // Shared state counter is sized for the longest interval it must time.
    localparam int C_MAX_LH  = (LOADER_RESET_CYCLES > HOLD_CYCLES) ? LOADER_RESET_CYCLES : HOLD_CYCLES;
    localparam int C_MAX_CNT = (C_MAX_LH > LOAD_TIMEOUT) ? C_MAX_LH : LOAD_TIMEOUT;
    localparam int C_CNT_W   = $clog2(C_MAX_CNT) + 1;
    localparam int C_DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [C_CNT_W-1:0] C_LRST_LAST = C_CNT_W'(LOADER_RESET_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(HOLD_CYCLES - 1);
    // Only meaningful when LOAD_TIMEOUT is non-zero; the LOAD branch guards on that.
    localparam logic [C_CNT_W-1:0] C_LOAD_LAST = C_CNT_W'(LOAD_TIMEOUT - 1);
    localparam logic [C_DB_W-1:0]  C_DB_LAST   = C_DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_LRST      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic                   r_btn_db;
    logic [C_DB_W-1:0]      r_db_cnt;
    state_t                 r_state;
    logic [C_CNT_W-1:0]     r_cnt;

    state_t                 w_state_nxt;
    logic [C_CNT_W-1:0]     w_cnt_nxt;
    logic                   w_timeout;
    logic                   w_lock;
    logic                   w_btn;
    logic                   w_press;
    logic                   w_all_ready;

    assign w_lock      = r_lock_sync[SYNC_STAGES-1];
    assign w_btn       = r_btn_sync[SYNC_STAGES-1];
    assign w_press     = ~r_btn_db;
    assign w_all_ready = &ready;

    // Bring the asynchronous lock and button inputs into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '1;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn_n};
        end
    end

    // Accept a new button level only after it has differed for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_db <= 1'b1;
            r_db_cnt <= '0;
        end else if (w_btn == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == C_DB_LAST) begin
            r_btn_db <= ~r_btn_db;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Next-state and interval counter; lock loss overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_timeout   = 1'b0;
        if (!w_lock) begin
            w_state_nxt = ST_WAIT_LOCK;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    w_state_nxt = ST_LRST;
                end
                ST_LRST: begin
                    if (r_cnt == C_LRST_LAST) w_state_nxt = ST_LOAD;
                    else                      w_cnt_nxt   = r_cnt + 1'b1;
                end
                ST_LOAD: begin
                    if (w_all_ready) begin
                        w_state_nxt = ST_HOLD;
                    end else if (LOAD_TIMEOUT != 0) begin
                        if (r_cnt == C_LOAD_LAST) begin
                            w_timeout   = 1'b1;
                            w_state_nxt = ST_LRST;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // A loader dropping out matters more than the hold count.
                    if (!w_all_ready)              w_state_nxt = ST_LOAD;
                    else if (w_press)              w_cnt_nxt   = '0;
                    else if (r_cnt == C_HOLD_LAST) w_state_nxt = ST_RUN;
                    else                           w_cnt_nxt   = r_cnt + 1'b1;
                end
                ST_RUN: begin
                    if (w_press)           w_state_nxt = (RELOAD_ON_BTN != 0) ? ST_LRST : ST_HOLD;
                    else if (!w_all_ready) w_state_nxt = ST_LOAD;
                end
                default: begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            endcase
        end
        // Each state times its own interval from zero.
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // State register with Moore outputs decoded from the incoming state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_WAIT_LOCK;
            r_cnt        <= '0;
            loader_reset <= 1'b1;
            cpu_reset    <= 1'b1;
            boot_done    <= 1'b0;
            led_n        <= 1'b1;
            timeout_err  <= 1'b0;
            retry_count  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            loader_reset <= (w_state_nxt == ST_WAIT_LOCK) || (w_state_nxt == ST_LRST);
            cpu_reset    <= (w_state_nxt != ST_RUN);
            boot_done    <= (w_state_nxt == ST_RUN);
            led_n        <= (w_state_nxt != ST_RUN);
            if (w_timeout) begin
                timeout_err <= 1'b1;
                if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boot_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_boot_sequencer
// Description : Self-checking bench for boot_sequencer. Two instances share
//               stimulus: A (button resets CPU only) and B (button reloads).
//               A cycle-level behavioural model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int LRC  = 4;
    localparam int HC   = 16;
    localparam int LT   = 100;

    localparam int M_WAIT = 0;
    localparam int M_LRST = 1;
    localparam int M_LOAD = 2;
    localparam int M_HOLD = 3;
    localparam int M_RUN  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       btn_n = 1'b1;
    logic [1:0] ready = 2'b00;

    logic       lr_a, cpu_a, bd_a, led_a, err_a;
    logic       lr_b, cpu_b, bd_b, led_b, err_b;
    logic [7:0] rc_a, rc_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Model state
    int         m_st [2];
    int         m_t  [2];
    int         m_rc [2];
    bit         m_err[2];
    logic [SYNC-1:0] m_lock_p;
    logic [SYNC-1:0] m_btn_p;
    bit         m_db;
    int         m_stable;

    boot_sequencer #(
        .NUM_READY(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .LOADER_RESET_CYCLES(LRC), .HOLD_CYCLES(HC), .LOAD_TIMEOUT(LT), .RELOAD_ON_BTN(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .pll_locked(pll_locked), .btn_n(btn_n), .ready(ready),
        .loader_reset(lr_a), .cpu_reset(cpu_a), .boot_done(bd_a), .led_n(led_a),
        .timeout_err(err_a), .retry_count(rc_a)
    );

    boot_sequencer #(
        .NUM_READY(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .LOADER_RESET_CYCLES(LRC), .HOLD_CYCLES(HC), .LOAD_TIMEOUT(LT), .RELOAD_ON_BTN(1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .pll_locked(pll_locked), .btn_n(btn_n), .ready(ready),
        .loader_reset(lr_b), .cpu_reset(cpu_b), .boot_done(bd_b), .led_n(led_b),
        .timeout_err(err_b), .retry_count(rc_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // sel: 0 loader_reset, 1 cpu_reset, 2 boot_done, 3 led_n, 4 timeout_err, 5 retry_count
    function automatic int dut_out(input int k, input int sel);
        int v;
        v = 0;
        if (k == 0) begin
            case (sel)
                0: v = int'(lr_a);
                1: v = int'(cpu_a);
                2: v = int'(bd_a);
                3: v = int'(led_a);
                4: v = int'(err_a);
                default: v = int'(rc_a);
            endcase
        end else begin
            case (sel)
                0: v = int'(lr_b);
                1: v = int'(cpu_b);
                2: v = int'(bd_b);
                3: v = int'(led_b);
                4: v = int'(err_b);
                default: v = int'(rc_b);
            endcase
        end
        return v;
    endfunction

    function automatic int model_out(input int k, input int sel);
        int v;
        case (sel)
            0: v = (m_st[k] == M_WAIT || m_st[k] == M_LRST) ? 1 : 0;
            1: v = (m_st[k] != M_RUN) ? 1 : 0;
            2: v = (m_st[k] == M_RUN) ? 1 : 0;
            3: v = (m_st[k] != M_RUN) ? 1 : 0;
            4: v = int'(m_err[k]);
            default: v = m_rc[k];
        endcase
        return v;
    endfunction

    function automatic string out_name(input int sel);
        string s;
        case (sel)
            0: s = "loader_reset";
            1: s = "cpu_reset";
            2: s = "boot_done";
            3: s = "led_n";
            4: s = "timeout_err";
            default: s = "retry_count";
        endcase
        return s;
    endfunction

    // One sequencer step from the boot rules; channel 1 reloads on a button press.
    function automatic void model_fsm(input int k, input bit lock_s, input bit press, input bit allr);
        int ns;
        bit hold_clear;
        ns = m_st[k];
        hold_clear = 1'b0;
        if (!lock_s) begin
            ns = M_WAIT;
        end else begin
            case (m_st[k])
                M_WAIT: ns = M_LRST;
                M_LRST: if (m_t[k] + 1 == LRC) ns = M_LOAD;
                M_LOAD: begin
                    if (allr) ns = M_HOLD;
                    else if (m_t[k] + 1 == LT) begin
                        ns = M_LRST;
                        m_err[k] = 1'b1;
                        if (m_rc[k] < 255) m_rc[k] = m_rc[k] + 1;
                    end
                end
                M_HOLD: begin
                    if (!allr) ns = M_LOAD;
                    else if (press) hold_clear = 1'b1;
                    else if (m_t[k] + 1 == HC) ns = M_RUN;
                end
                default: begin
                    if (press) ns = (k == 1) ? M_LRST : M_HOLD;
                    else if (!allr) ns = M_LOAD;
                end
            endcase
        end
        if (ns != m_st[k] || hold_clear) m_t[k] = 0;
        else m_t[k] = m_t[k] + 1;
        m_st[k] = ns;
    endfunction

    // Advance the model on each rising edge from the inputs present at that edge.
    always @(posedge clk) begin
        bit s_lock, s_btn, press;
        cyc++;
        if (reset) begin
            m_lock_p = '0;
            m_btn_p  = '1;
            m_db     = 1'b1;
            m_stable = 0;
            for (int k = 0; k < 2; k++) begin
                m_st[k] = M_WAIT; m_t[k] = 0; m_rc[k] = 0; m_err[k] = 1'b0;
            end
        end else begin
            s_lock = m_lock_p[SYNC-1];
            s_btn  = m_btn_p[SYNC-1];
            press  = !m_db;
            for (int k = 0; k < 2; k++) model_fsm(k, s_lock, press, &ready);
            if (s_btn == m_db) m_stable = 0;
            else begin
                m_stable++;
                if (m_stable == DEB) begin
                    m_db = !m_db;
                    m_stable = 0;
                end
            end
            m_lock_p = {m_lock_p[SYNC-2:0], pll_locked};
            m_btn_p  = {m_btn_p[SYNC-2:0], btn_n};
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++)
                for (int s = 0; s < 6; s++)
                    chk($sformatf("cmp%s_%s", (k == 0) ? "A" : "B", out_name(s)),
                        dut_out(k, s), model_out(k, s));
        end
    end

    // sel: 0 lr_a, 1 cpu_a, 2 lr_b, 3 cpu_b. Returns the cycle the level was reached.
    task automatic wait_for(input int sel, input int val, input int lim, input string name, output int t);
        int n;
        int idx;
        n = 0;
        idx = (sel >= 2) ? 1 : 0;
        while (dut_out(idx, sel % 2) != val && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (dut_out(idx, sel % 2) != val) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, got %0d expected %0d", name, lim,
                     dut_out(idx, sel % 2), val);
        end
        t = cyc;
    endtask

    initial begin
        int t0, t1, t2, t3, tf, tr, tb, prev;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_loader_reset", int'(lr_a), 1);
        chk("rst_cpu_reset", int'(cpu_a), 1);
        chk("rst_boot_done", int'(bd_a), 0);
        chk("rst_led_n", int'(led_a), 1);
        chk("rst_retry_count", int'(rc_a), 0);
        reset = 1'b0;

        // Power-on: lock at cycle 10, both loaders ready 5 cycles into LOAD.
        while (cyc < 10) @(negedge clk);
        pll_locked = 1'b1;
        t0 = cyc;
        wait_for(0, 0, 50, "pwr_load_entry", t1);
        // 2 sync + 1 into LRST + 4 LRST cycles
        chk("pwr_lock_to_load", t1 - t0, 7);
        repeat (5) @(negedge clk);
        ready = 2'b11;
        wait_for(1, 0, 60, "pwr_run_entry", t3);
        // 5 in LOAD, 1 into HOLD, 16 HOLD cycles
        chk("pwr_load_to_run", t3 - t1, 22);
        chk("pwr_led_on", int'(led_a), 0);

        // Button glitch shorter than the debounce window: no effect.
        btn_n = 1'b0;
        repeat (5) @(negedge clk);
        btn_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_cpu_a", int'(cpu_a), 0);
        chk("glitch_cpu_b", int'(cpu_b), 0);

        // Valid 20-cycle press.
        btn_n = 1'b0;
        tf = cyc;
        wait_for(1, 1, 40, "press_cpu_rise", t2);
        // 2 sync + 8 debounce + 1 state register
        chk("press_to_cpu_reset", t2 - tf, 11);
        chk("press_b_loader_reset", int'(lr_b), 1);
        wait_for(2, 0, 20, "press_b_lrst_end", tb);
        chk("press_b_lrst_width", tb - t2, 4);
        while (cyc < tf + 20) @(negedge clk);
        btn_n = 1'b1;
        tr = cyc;
        wait_for(1, 0, 60, "release_run", t3);
        // 2 sync + 8 debounce + 16 hold
        chk("release_to_run_a", t3 - tr, 26);
        chk("release_run_b", int'(cpu_b), 0);

        // Loader 1 never ready: periodic retries.
        ready = 2'b01;
        tr = cyc;
        wait_for(0, 1, 150, "retry1", t1);
        chk("retry_first_pulse", t1 - tr, 101);
        chk("retry_count_1", int'(rc_a), 1);
        chk("timeout_err_set", int'(err_a), 1);
        wait_for(0, 0, 20, "retry1_end", t2);
        chk("retry_pulse_width", t2 - t1, 4);
        prev = t1;
        wait_for(0, 1, 150, "retry2", t1);
        chk("retry_period", t1 - prev, 104);
        chk("retry_count_2", int'(rc_a), 2);
        wait_for(0, 0, 20, "retry2_end", t2);
        wait_for(0, 1, 150, "retry3", t1);
        chk("retry_count_3", int'(rc_b), 3);
        repeat (256 * 104) @(negedge clk);
        chk("retry_sat_a", int'(rc_a), 255);
        chk("retry_sat_b", int'(rc_b), 255);

        // Lock loss in RUN reruns the sequence; error flags survive.
        ready = 2'b11;
        wait_for(1, 0, 200, "rerun_run", t3);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        chk("lockloss_cpu_reset", int'(cpu_a), 1);
        chk("lockloss_loader_reset", int'(lr_a), 1);
        chk("lockloss_err_kept", int'(err_a), 1);
        chk("lockloss_rc_kept", int'(rc_a), 255);
        wait_for(1, 0, 100, "lockloss_rerun", t3);
        chk("lockloss_rc_after", int'(rc_b), 255);

        // Reset while in LOAD.
        ready = 2'b00;
        repeat (3) @(negedge clk);
        chk("load_state_lr", int'(lr_a), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_load_lr", int'(lr_a), 1);
        chk("rst_in_load_err", int'(err_a), 0);
        chk("rst_in_load_rc", int'(rc_b), 0);

        // Reset while in HOLD.
        ready = 2'b11;
        wait_for(0, 0, 50, "to_hold", t1);
        repeat (3) @(negedge clk);
        chk("hold_state_cpu", int'(cpu_a), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_hold_lr", int'(lr_a), 1);
        chk("rst_in_hold_bd", int'(bd_b), 0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
